// File: rtl/line_fifo_ctrl.sv
// Line FIFO controller: tracks whole-line slots in an external buffer RAM.
// Define LINE_FIFO_OVERFLOW_DROP_EN to drop lines when full instead of stalling.
module line_fifo_ctrl #(
   parameter int LINE_SIZE = 20,
   parameter int NUM_LINES = 5,
   parameter int ADDR_W    = $clog2(NUM_LINES * LINE_SIZE)
) (
   input  logic                           clock_in,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic                           in_sol,
   output logic                           in_ready,
   output logic                           wr_en,
   output logic [ADDR_W-1:0]              wr_addr,
   input  logic                           rd_req,
   output logic                           rd_busy,
   output logic                           rd_en,
   output logic [ADDR_W-1:0]              rd_addr,
   output logic                           rd_sol,
   output logic                           rd_eol,
   output logic [$clog2(NUM_LINES+1)-1:0] lines_avail,
   output logic                           overflow
);

   localparam int CW  = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
   localparam int LW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int AVW = $clog2(NUM_LINES + 1);

   localparam logic [CW-1:0]  COL_LAST  = CW'(LINE_SIZE - 1);
   localparam logic [LW-1:0]  LINE_LAST = LW'(NUM_LINES - 1);
   localparam logic [AVW-1:0] AV_FULL   = AVW'(NUM_LINES);

`ifdef LINE_FIFO_OVERFLOW_DROP_EN
   typedef enum logic [1:0] {W_IDLE, W_LINE, W_DROP} wr_state_t;
`else
   typedef enum logic [1:0] {W_IDLE, W_LINE} wr_state_t;
`endif
   typedef enum logic {R_IDLE, R_LINE} rd_state_t;

   wr_state_t      wr_state_q, wr_state_d;
   logic [LW-1:0]  wr_line_q, wr_line_d;
   logic [CW-1:0]  wr_col_q, wr_col_d;
   logic [CW-1:0]  wr_col_eff;
   rd_state_t      rd_state_q, rd_state_d;
   logic [LW-1:0]  rd_line_q, rd_line_d;
   logic [CW-1:0]  rd_col_q, rd_col_d;
   logic [AVW-1:0] lines_avail_q, lines_avail_d;
   logic           full;
   logic           accept;
   logic           commit;
   logic           rel;

   assign full = (lines_avail_q == AV_FULL) && (wr_state_q == W_IDLE);

`ifdef LINE_FIFO_OVERFLOW_DROP_EN
   logic overflow_q, overflow_d;
   assign in_ready = ~reset;
   assign overflow = overflow_q;
`else
   assign in_ready = ~reset & ~full;
   assign overflow = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   // Write side: line assembly, restart on in_sol, commit on last column.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_line_d  = wr_line_q;
      wr_col_d   = wr_col_q;
      wr_col_eff = wr_col_q;
      wr_en      = 1'b0;
      commit     = 1'b0;
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
      overflow_d = overflow_q;
`endif
      unique case (wr_state_q)
         W_IDLE: begin
            wr_col_eff = '0;
            if (accept && in_sol) begin
               if (full) begin
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
                  wr_state_d = W_DROP;
                  wr_col_d   = CW'(1);
                  overflow_d = 1'b1;
`endif
               end else begin
                  wr_en      = 1'b1;
                  wr_state_d = W_LINE;
                  wr_col_d   = CW'(1);
               end
            end
         end
         W_LINE: begin
            if (accept) begin
               wr_en = 1'b1;
               if (in_sol) begin
                  wr_col_eff = '0;
                  wr_col_d   = CW'(1);
               end else if (wr_col_q == COL_LAST) begin
                  commit     = 1'b1;
                  wr_col_d   = '0;
                  wr_state_d = W_IDLE;
                  wr_line_d  = (wr_line_q == LINE_LAST) ?
                               '0 : wr_line_q + LW'(1);
               end else begin
                  wr_col_d = wr_col_q + CW'(1);
               end
            end
         end
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
         W_DROP: begin
            wr_col_eff = '0;
            if (accept) begin
               if (wr_col_q == COL_LAST) begin
                  wr_col_d   = '0;
                  wr_state_d = W_IDLE;
               end else begin
                  wr_col_d = wr_col_q + CW'(1);
               end
            end
         end
`endif
         default: begin
            wr_state_d = W_IDLE;
         end
      endcase
   end

   assign wr_addr = ADDR_W'(wr_line_q) * ADDR_W'(LINE_SIZE)
                  + ADDR_W'(wr_col_eff);

   // Read side: one request streams a whole committed line, then releases it.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_line_d  = rd_line_q;
      rd_col_d   = rd_col_q;
      rel        = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            if (rd_req && (lines_avail_q != '0)) begin
               rd_state_d = R_LINE;
               rd_col_d   = '0;
            end
         end
         R_LINE: begin
            if (rd_col_q == COL_LAST) begin
               rel        = 1'b1;
               rd_col_d   = '0;
               rd_state_d = R_IDLE;
               rd_line_d  = (rd_line_q == LINE_LAST) ?
                            '0 : rd_line_q + LW'(1);
            end else begin
               rd_col_d = rd_col_q + CW'(1);
            end
         end
         default: begin
            rd_state_d = R_IDLE;
         end
      endcase
   end

   assign rd_busy = (rd_state_q == R_LINE);
   assign rd_en   = rd_busy;
   assign rd_sol  = rd_en && (rd_col_q == '0);
   assign rd_eol  = rd_en && (rd_col_q == COL_LAST);
   assign rd_addr = ADDR_W'(rd_line_q) * ADDR_W'(LINE_SIZE)
                  + ADDR_W'(rd_col_q);

   // Occupancy: commit and release in one cycle cancel out.
   always_comb begin
      lines_avail_d = lines_avail_q;
      if (commit && !rel) begin
         lines_avail_d = lines_avail_q + AVW'(1);
      end else if (rel && !commit) begin
         lines_avail_d = lines_avail_q - AVW'(1);
      end
   end

   assign lines_avail = lines_avail_q;

   // State registers; reset drops any partial line.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         wr_state_q    <= W_IDLE;
         wr_line_q     <= '0;
         wr_col_q      <= '0;
         rd_state_q    <= R_IDLE;
         rd_line_q     <= '0;
         rd_col_q      <= '0;
         lines_avail_q <= '0;
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
         overflow_q    <= 1'b0;
`endif
      end else begin
         wr_state_q    <= wr_state_d;
         wr_line_q     <= wr_line_d;
         wr_col_q      <= wr_col_d;
         rd_state_q    <= rd_state_d;
         rd_line_q     <= rd_line_d;
         rd_col_q      <= rd_col_d;
         lines_avail_q <= lines_avail_d;
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
         overflow_q    <= overflow_d;
`endif
      end
   end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Directed bench for line_fifo_ctrl (LINE_SIZE 20, NUM_LINES 5).
// Expectations follow LINE_FIFO_OVERFLOW_DROP_EN when it is defined.
module tb_line_fifo_ctrl;

   localparam int AW  = 7;
   localparam int AVW = 3;
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
   localparam logic DROP_EN = 1'b1;
`else
   localparam logic DROP_EN = 1'b0;
`endif

   logic           clock_in = 1'b0;
   logic           reset    = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_sol   = 1'b0;
   logic           rd_req   = 1'b0;
   logic           in_ready;
   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic           rd_busy;
   logic           rd_en;
   logic [AW-1:0]  rd_addr;
   logic           rd_sol;
   logic           rd_eol;
   logic [AVW-1:0] lines_avail;
   logic           overflow;

   line_fifo_ctrl dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_sol      (in_sol),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .rd_req      (rd_req),
      .rd_busy     (rd_busy),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_sol      (rd_sol),
      .rd_eol      (rd_eol),
      .lines_avail (lines_avail),
      .overflow    (overflow)
   );

   always #5 clock_in = ~clock_in;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic rst;
      logic v;
      logic s;
      logic rq;
      logic exp_rdy;
      logic exp_we;
      int   exp_addr;
      int   exp_av;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp,
                  $time);
      end
   endtask

   task automatic drive(input logic rst, input logic v, input logic s,
                        input logic rq);
      @(negedge clock_in);
      reset    = rst;
      in_valid = v;
      in_sol   = s;
      rd_req   = rq;
      #1;
   endtask

   task automatic chk_all_zero();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_busy", rd_busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_sol", rd_sol, 0);
      chk("rst_rd_eol", rd_eol, 0);
      chk("rst_lines_avail", lines_avail, 0);
      chk("rst_overflow", overflow, 0);
   endtask

   task automatic write_line(input int base, input int av);
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("wl_in_ready", in_ready, 1);
         chk("wl_wr_en", wr_en, 1);
         chk("wl_wr_addr", wr_addr, base + k);
         chk("wl_lines_avail", lines_avail, av);
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
      for (int i = 0; i < 20; i++) begin
         tbl[i+1] = '{1'b0, 1'b1, i == 0, 1'b0, 1'b1, 1'b1, i, 0};
      end
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20, 1};

      // first line after reset
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].rq);
         if (tbl[i].rst) chk_all_zero();
         chk("tbl_in_ready", in_ready, tbl[i].exp_rdy);
         chk("tbl_wr_en", wr_en, tbl[i].exp_we);
         chk("tbl_wr_addr", wr_addr, tbl[i].exp_addr);
         chk("tbl_lines_avail", lines_avail, tbl[i].exp_av);
      end

      // fill remaining slots
      for (int l = 1; l < 5; l++) write_line(l * 20, l);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_lines_avail", lines_avail, 5);
      chk("full_in_ready", in_ready, DROP_EN);

      // sixth line offered while full
`ifdef LINE_FIFO_OVERFLOW_DROP_EN
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("drop_in_ready", in_ready, 1);
         chk("drop_wr_en", wr_en, 0);
         chk("drop_lines_avail", lines_avail, 5);
         chk("drop_overflow", overflow, (k == 0) ? 0 : 1);
      end
`else
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_wr_en", wr_en, 0);
         chk("bp_lines_avail", lines_avail, 5);
      end
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("after_full_overflow", overflow, DROP_EN);
      chk("after_full_lines_avail", lines_avail, 5);

      // read slot 0 while the extra line keeps being offered
      drive(1'b0, !DROP_EN, !DROP_EN, 1'b1);
      chk("rq_rd_en", rd_en, 0);
      chk("rq_in_ready", in_ready, DROP_EN);
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, !DROP_EN, !DROP_EN, k == 5);
         chk("rd_en", rd_en, 1);
         chk("rd_busy", rd_busy, 1);
         chk("rd_addr", rd_addr, k);
         chk("rd_sol", rd_sol, k == 0);
         chk("rd_eol", rd_eol, k == 19);
         chk("rd_lines_avail", lines_avail, 5);
         chk("rd_in_ready", in_ready, DROP_EN);
         chk("rd_wr_en", wr_en, 0);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk("rel_rd_en", rd_en, 0);
      chk("rel_rd_busy", rd_busy, 0);
      chk("rel_lines_avail", lines_avail, 4);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_wr_en", wr_en, 1);
      chk("rel_wr_addr", wr_addr, 0);

      // reset; rd_req with nothing committed is ignored
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_all_zero();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("empty_in_ready", in_ready, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("empty_rd_busy", rd_busy, 0);
      chk("empty_rd_en", rd_en, 0);

      // restart on in_sol mid-line in slot 1
      write_line(0, 0);
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("pre_wr_addr", wr_addr, 20 + k);
         chk("pre_lines_avail", lines_avail, 1);
      end
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("rs_wr_en", wr_en, 1);
         chk("rs_wr_addr", wr_addr, 20 + k);
         chk("rs_lines_avail", lines_avail, 1);
      end

      // commit and release in the same cycle
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("cr_start_lines_avail", lines_avail, 2);
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("cr_wr_en", wr_en, 1);
         chk("cr_wr_addr", wr_addr, 40 + k);
         chk("cr_rd_en", rd_en, 1);
         chk("cr_rd_addr", rd_addr, k);
         chk("cr_rd_eol", rd_eol, k == 19);
         chk("cr_lines_avail", lines_avail, 2);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("cr_end_lines_avail", lines_avail, 2);
      chk("cr_end_rd_busy", rd_busy, 0);

      // reset in the middle of a line
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, k == 0, 1'b0);
         chk("ml_wr_addr", wr_addr, 60 + k);
      end
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      chk_all_zero();
      write_line(0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_lines_avail", lines_avail, 1);
      chk("post_rst_wr_addr", wr_addr, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

endmodule
